// File: rtl/cva6_fifo_pop_stage_pkg.sv
// cva6_fifo_pop_stage_pkg: pointer helper for non-power-of-two circular buffers
package cva6_fifo_pop_stage_pkg;
  function automatic int unsigned next_ptr(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/cva6_fifo_pop_stage.sv
// cva6_fifo_pop_stage: drains a FIFO into a registered valid/ready stream without a ready-to-pop path
module cva6_fifo_pop_stage
  import cva6_fifo_pop_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned OUT_DEPTH    = 2 + READ_LATENCY,
  localparam int unsigned CW          = $clog2(OUT_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          fifo_empty_i,
  input  dtype          fifo_data_i,
  output logic          fifo_pop_o,
  output logic          valid_o,
  output dtype          data_o,
  input  logic          ready_i,
  output logic [CW-1:0] count_o
);
  localparam int unsigned PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  dtype buf_q [OUT_DEPTH];
  dtype buf_d [OUT_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic inflight_q, inflight_d, capture, transfer;
  // Slots are reserved at pop time, counting the word still in flight from a registered-read FIFO
  assign fifo_pop_o = ~fifo_empty_i & ~flush_i & ~rst_i & ((32'(occ_q) + 32'(inflight_q)) < OUT_DEPTH);
  assign valid_o    = occ_q != '0;
  assign data_o     = buf_q[rd_q];
  assign count_o    = occ_q;
  assign transfer   = valid_o & ready_i;
  always_comb begin
    capture    = ((READ_LATENCY == 1) ? inflight_q : fifo_pop_o) & ~flush_i;
    inflight_d = (READ_LATENCY == 1) ? fifo_pop_o : 1'b0;
    occ_d      = flush_i ? '0 : occ_q + CW'(capture) - CW'(transfer);
    wr_d       = flush_i ? '0 : capture ? PW'(next_ptr(32'(wr_q), OUT_DEPTH)) : wr_q;
    rd_d       = flush_i ? '0 : transfer ? PW'(next_ptr(32'(rd_q), OUT_DEPTH)) : rd_q;
    buf_d      = buf_q;
    if (capture) buf_d[wr_q] = fifo_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
    end
  end
  if (READ_LATENCY > 1) begin : g_bad_latency
    $error("cva6_fifo_pop_stage: READ_LATENCY must be 0 or 1");
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(capture && occ_q == CW'(OUT_DEPTH)))
    else $fatal(1, "cva6_fifo_pop_stage: capture into a full output buffer");
endmodule
